// File: rtl/mat_pkg.sv
// Shared types, latency helper and FSM/error encodings for the double-buffered matrix unit.
package mat_pkg;

  localparam int MAT_DATA_W = 8;
  localparam int MAT_N      = 4;
  localparam int MAT_ACC_W  = 2*MAT_DATA_W + $clog2(MAT_N);

  typedef logic signed [MAT_DATA_W-1:0] data_t;
  typedef logic signed [MAT_ACC_W-1:0]  acc_t;

  typedef enum logic {SH_FREE, SH_LOCKED} sh_state_e;

  localparam int ERR_BAD_IDX = 0;
  localparam int ERR_COMMIT  = 1;

  function automatic int lat(input int n);
    return 2*n;
  endfunction

endpackage

// File: rtl/mat_pe_db.sv
// Weight-stationary PE with two weight banks; the bank is chosen per vector by the travelling tag.
module mat_pe_db
  import mat_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic [1:0]               w_we,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     vld_in,
  input  logic                     tag_in,
  input  logic signed [ACC_W-1:0]  psum_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     vld_out,
  output logic                     tag_out,
  output logic signed [ACC_W-1:0]  psum_out
);

  logic signed [DATA_W-1:0] w_bank [2];

  function automatic logic signed [ACC_W-1:0] mac(input logic signed [ACC_W-1:0]  acc,
                                                  input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] prod;
    prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    return acc + ACC_W'(prod);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_bank[0] <= '0;
      w_bank[1] <= '0;
      vld_out   <= 1'b0;
    end else begin
      if (w_we[0]) w_bank[0] <= w_data;
      if (w_we[1]) w_bank[1] <= w_data;
      vld_out <= vld_in;
    end
  end

  // Stage boundary: data/tag east, partial sum south
  always_ff @(posedge clock) begin
    data_out <= data_in;
    tag_out  <= tag_in;
    psum_out <= mac(psum_in, data_in, w_bank[tag_in]);
  end

endmodule

// File: rtl/mat_unit_db.sv
// Double-buffered weight-stationary systolic unit: y = x*W at one vector per cycle, latency 2*N.
module mat_unit_db
  import mat_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(N),
  parameter int IDX_W  = $clog2(N)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [N-1:0][DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic [N-1:0][ACC_W-1:0]  out_data,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [IDX_W-1:0]         w_row_idx,
  input  logic [N-1:0][DATA_W-1:0] w_row_data,
  input  logic                     w_commit,
  output logic                     bank_active,
  output logic                     busy,
  output logic [1:0]               err
);

  localparam int LAT   = lat(N);
  localparam int CNT_W = $clog2(LAT+1);

  sh_state_e        state;
  logic [CNT_W-1:0] drain_cnt;
  logic [N-1:0]     mask, mask_nxt, row_sel;
  logic             wr_fire, idx_ok;
  logic [1:0]       row_we [N];

  always_comb begin
    idx_ok   = 32'(w_row_idx) < N;
    wr_fire  = w_valid && w_ready;
    mask_nxt = mask;
    for (int i = 0; i < N; i++) begin
      row_sel[i] = wr_fire && idx_ok && (w_row_idx == IDX_W'(i));
      row_we[i]  = row_sel[i] ? (bank_active ? 2'b01 : 2'b10) : 2'b00;
    end
    mask_nxt = mask | row_sel;
  end

  // A same-cycle write is folded into mask_nxt before the commit check
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SH_FREE;
      drain_cnt   <= '0;
      bank_active <= 1'b0;
      w_ready     <= 1'b1;
      mask        <= '0;
      err         <= '0;
    end else begin
      mask <= mask_nxt;
      if (wr_fire && !idx_ok) err[ERR_BAD_IDX] <= 1'b1;
      case (state)
        SH_FREE: begin
          if (w_commit) begin
            if (&mask_nxt) begin
              bank_active <= ~bank_active;
              mask        <= '0;
              drain_cnt   <= CNT_W'(LAT);
              w_ready     <= 1'b0;
              state       <= SH_LOCKED;
            end else begin
              err[ERR_COMMIT] <= 1'b1;
            end
          end
        end
        SH_LOCKED: begin
          if (w_commit) err[ERR_COMMIT] <= 1'b1;
          drain_cnt <= drain_cnt - CNT_W'(1);
          if (drain_cnt == CNT_W'(1)) begin
            state   <= SH_FREE;
            w_ready <= 1'b1;
          end
        end
        default: state <= SH_FREE;
      endcase
    end
  end

  // Stage p0: input capture with bank tag
  logic                     vld_p0, tag_p0;
  logic signed [DATA_W-1:0] x_p0 [N];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vld_p0 <= 1'b0;
    else          vld_p0 <= in_valid;
  end

  always_ff @(posedge clock) begin
    tag_p0 <= bank_active;
    for (int i = 0; i < N; i++) x_p0[i] <= in_data[i];
  end

  logic signed [DATA_W-1:0] h_data [N][N+1];
  logic                     h_vld  [N][N+1];
  logic                     h_tag  [N][N+1];
  logic signed [ACC_W-1:0]  v_sum  [N+1][N];

  // Stage p1: input skew, row i delayed i cycles
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign h_data[0][0] = x_p0[0];
      assign h_vld[0][0]  = vld_p0;
      assign h_tag[0][0]  = tag_p0;
    end else begin : g_chain
      logic signed [DATA_W-1:0] sk_data_p1 [i];
      logic                     sk_tag_p1  [i];
      logic                     sk_vld_p1  [i];

      always_ff @(posedge clock) begin
        sk_data_p1[0] <= x_p0[i];
        sk_tag_p1[0]  <= tag_p0;
        for (int k = 1; k < i; k++) begin
          sk_data_p1[k] <= sk_data_p1[k-1];
          sk_tag_p1[k]  <= sk_tag_p1[k-1];
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < i; k++) sk_vld_p1[k] <= 1'b0;
        end else begin
          sk_vld_p1[0] <= vld_p0;
          for (int k = 1; k < i; k++) sk_vld_p1[k] <= sk_vld_p1[k-1];
        end
      end

      assign h_data[i][0] = sk_data_p1[i-1];
      assign h_vld[i][0]  = sk_vld_p1[i-1];
      assign h_tag[i][0]  = sk_tag_p1[i-1];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_top
    assign v_sum[0][j] = '0;
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      mat_pe_db #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clock    (clock),
        .reset_n  (reset_n),
        .w_data   (w_row_data[j]),
        .w_we     (row_we[i]),
        .data_in  (h_data[i][j]),
        .vld_in   (h_vld[i][j]),
        .tag_in   (h_tag[i][j]),
        .psum_in  (v_sum[i][j]),
        .data_out (h_data[i][j+1]),
        .vld_out  (h_vld[i][j+1]),
        .tag_out  (h_tag[i][j+1]),
        .psum_out (v_sum[i+1][j])
      );
    end
  end

  // Stage p2: output deskew, column j delayed N-1-j cycles
  logic signed [ACC_W-1:0] y_p2 [N];
  logic                    dsk_vld_p2 [N-1];

  for (genvar j = 0; j < N; j++) begin : g_dsk
    if (j == N-1) begin : g_direct
      assign y_p2[j] = v_sum[N][j];
    end else begin : g_chain
      logic signed [ACC_W-1:0] dsk_p2 [N-1-j];
      always_ff @(posedge clock) begin
        dsk_p2[0] <= v_sum[N][j];
        for (int k = 1; k < N-1-j; k++) dsk_p2[k] <= dsk_p2[k-1];
      end
      assign y_p2[j] = dsk_p2[N-2-j];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N-1; k++) dsk_vld_p2[k] <= 1'b0;
    end else begin
      dsk_vld_p2[0] <= h_vld[N-1][1];
      for (int k = 1; k < N-1; k++) dsk_vld_p2[k] <= dsk_vld_p2[k-1];
    end
  end

  // Stage p3: output register, data held between valid results
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= dsk_vld_p2[N-2];
      if (dsk_vld_p2[N-2]) begin
        for (int j = 0; j < N; j++) out_data[j] <= y_p2[j];
      end
    end
  end

  logic [LAT-1:0] vld_hist;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vld_hist <= '0;
    else          vld_hist <= {vld_hist[LAT-2:0], in_valid};
  end

  assign busy = |vld_hist;

endmodule

// File: tb/tb_mat_unit_db.sv
// Directed bench for mat_unit_db with N=4, DATA_W=8, ACC_W=18 and a widened row index.
module tb_mat_unit_db;

  typedef logic [3:0][7:0]  vec_t;
  typedef logic [3:0][17:0] res_t;
  typedef struct { int cyc; res_t d; } obs_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  vec_t       in_data = '0;
  logic       out_valid;
  res_t       out_data;
  logic       w_valid = 1'b0;
  logic       w_ready;
  logic [2:0] w_row_idx = '0;
  vec_t       w_row_data = '0;
  logic       w_commit = 1'b0;
  logic       bank_active;
  logic       busy;
  logic [1:0] err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  obs_t obs_q[$];

  mat_unit_db #(.N(4), .DATA_W(8), .ACC_W(18), .IDX_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .w_valid(w_valid), .w_ready(w_ready),
    .w_row_idx(w_row_idx), .w_row_data(w_row_data), .w_commit(w_commit),
    .bank_active(bank_active), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    #2;
    if (out_valid) obs_q.push_back('{cyc, out_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t v4(input int a, input int b, input int c, input int d);
    vec_t r;
    r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
    return r;
  endfunction

  function automatic res_t r4(input int a, input int b, input int c, input int d);
    res_t r;
    r[0] = 18'(a); r[1] = 18'(b); r[2] = 18'(c); r[3] = 18'(d);
    return r;
  endfunction

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  task automatic write_row(input int idx, input vec_t d);
    w_valid = 1'b1; w_row_idx = 3'(idx); w_row_data = d;
    @(negedge clock);
    w_valid = 1'b0;
  endtask

  task automatic do_commit(output int tc);
    w_commit = 1'b1;
    @(negedge clock);
    w_commit = 1'b0;
    tc = cyc;
  endtask

  task automatic load_bank(input vec_t a, input vec_t b, input vec_t c, input vec_t d, output int tc);
    write_row(0, a); write_row(1, b); write_row(2, c); write_row(3, d);
    do_commit(tc);
  endtask

  task automatic drive_vec(input logic v, input vec_t d, output int e);
    in_valid = v; in_data = d;
    @(negedge clock);
    in_valid = 1'b0;
    e = cyc;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(1);
  endtask

  task automatic test_reset;
    int tc, e, d;
    load_bank(v4(1,1,1,1), v4(1,1,1,1), v4(1,1,1,1), v4(1,1,1,1), tc);
    obs_q.delete();
    drive_vec(1'b1, v4(1,1,1,1), e);
    ticks(8);
    checks++;
    if (obs_q.size() != 1 || out_data !== r4(4,4,4,4)) begin
      errors++; $display("FAIL pre_reset_result: got %0d outputs data %h expected 1 output %h", obs_q.size(), out_data, r4(4,4,4,4));
    end
    drive_vec(1'b1, v4(2,2,2,2), d);
    drive_vec(1'b1, v4(3,3,3,3), d);
    drive_vec(1'b1, v4(4,4,4,4), d);
    ticks(1);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_async: got %b expected 0", busy); end
    ticks(2);
    reset_n = 1'b1;
    obs_q.delete();
    checks++;
    if (w_ready !== 1'b1) begin errors++; $display("FAIL reset_w_ready: got %b expected 1", w_ready); end
    checks++;
    if (bank_active !== 1'b0) begin errors++; $display("FAIL reset_bank_active: got %b expected 0", bank_active); end
    checks++;
    if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    for (int k = 0; k < 20; k++) begin
      ticks(1);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: cycle %0d got %b expected 0", k, out_valid); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL reset_flushed: got %0d outputs expected 0", obs_q.size()); end
  endtask

  task automatic test_identity;
    int tc, e;
    load_bank(v4(1,0,0,0), v4(0,1,0,0), v4(0,0,1,0), v4(0,0,0,1), tc);
    checks++;
    if (bank_active !== 1'b1) begin errors++; $display("FAIL ident_bank_active: got %b expected 1", bank_active); end
    checks++;
    if (w_ready !== 1'b0) begin errors++; $display("FAIL ident_w_ready_commit: got %b expected 0", w_ready); end
    in_valid = 1'b1; in_data = v4(1,2,3,4);
    e = tc + 1;
    for (int k = 1; k <= 12; k++) begin
      ticks(1);
      in_valid = 1'b0;
      checks++;
      if (w_ready !== (k >= 8)) begin errors++; $display("FAIL ident_w_ready: edge tc+%0d got %b expected %b", k, w_ready, (k >= 8)); end
      checks++;
      if (out_valid !== (cyc == e + 8)) begin errors++; $display("FAIL ident_out_valid: edge t+%0d got %b expected %b", cyc - e, out_valid, (cyc == e + 8)); end
      if (cyc == e + 8) begin
        checks++;
        if (out_data !== r4(1,2,3,4)) begin errors++; $display("FAIL ident_data: got %h expected %h", out_data, r4(1,2,3,4)); end
      end
    end
  endtask

  task automatic test_streaming;
    int tc, e, d;
    int   ecyc [3];
    res_t edat [3];
    load_bank(v4(1,1,1,1), v4(1,1,1,1), v4(1,1,1,1), v4(1,1,1,1), tc);
    obs_q.delete();
    drive_vec(1'b1, v4(1,1,1,1), e);
    drive_vec(1'b1, v4(5,5,5,5), d);
    drive_vec(1'b0, v4(9,9,9,9), d);
    drive_vec(1'b1, v4(-1,2,0,3), d);
    ecyc = '{e + 8, e + 9, e + 11};
    edat = '{r4(4,4,4,4), r4(20,20,20,20), r4(4,4,4,4)};
    ticks(7);
    checks++;
    if (out_valid !== 1'b0 || out_data !== r4(20,20,20,20)) begin
      errors++; $display("FAIL stream_gap_hold: got valid %b data %h expected valid 0 data %h", out_valid, out_data, r4(20,20,20,20));
    end
    ticks(2);
    checks++;
    if (obs_q.size() != 3) begin errors++; $display("FAIL stream_count: got %0d expected 3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].cyc != ecyc[k] || obs_q[k].d !== edat[k]) begin
        errors++; $display("FAIL stream_out%0d: got edge %0d data %h expected edge %0d data %h", k, obs_q[k].cyc, obs_q[k].d, ecyc[k], edat[k]);
      end
    end
  endtask

  task automatic test_back_to_back_swap;
    int   tc, e0;
    res_t exp_d;
    load_bank(v4(1,0,0,0), v4(0,1,0,0), v4(0,0,1,0), v4(0,0,0,1), tc);
    ticks(9);
    write_row(0, v4(2,0,0,0)); write_row(1, v4(0,2,0,0));
    write_row(2, v4(0,0,2,0)); write_row(3, v4(0,0,0,2));
    obs_q.delete();
    e0 = cyc + 1;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1; in_data = v4(1,2,3,4); w_commit = (k == 5);
      ticks(1);
    end
    in_valid = 1'b0; w_commit = 1'b0;
    ticks(10);
    checks++;
    if (obs_q.size() != 12) begin errors++; $display("FAIL swap_count: got %0d expected 12", obs_q.size()); end
    for (int k = 0; k < 12 && k < obs_q.size(); k++) begin
      exp_d = (k <= 5) ? r4(1,2,3,4) : r4(2,4,6,8);
      checks++;
      if (obs_q[k].cyc != e0 + 8 + k || obs_q[k].d !== exp_d) begin
        errors++; $display("FAIL swap_out%0d: got edge %0d data %h expected edge %0d data %h", k, obs_q[k].cyc, obs_q[k].d, e0 + 8 + k, exp_d);
      end
    end
    checks++;
    if (err !== 2'b00) begin errors++; $display("FAIL swap_err: got %b expected 00", err); end
  endtask

  task automatic test_errors;
    int tc;
    ticks(10);
    load_bank(v4(7,0,0,0), v4(0,7,0,0), v4(0,0,7,0), v4(0,0,0,7), tc);
    w_commit = 1'b1; w_valid = 1'b1; w_row_idx = 3'd5;
    ticks(1);
    w_commit = 1'b0; w_valid = 1'b0;
    checks++;
    if (err !== 2'b10) begin errors++; $display("FAIL err_locked_commit: got %b expected 10", err); end
    checks++;
    if (bank_active !== 1'b1) begin errors++; $display("FAIL err_locked_bank: got %b expected 1", bank_active); end
    do_reset();
    checks++;
    if (err !== 2'b00) begin errors++; $display("FAIL err_reset_clear: got %b expected 00", err); end
    write_row(0, v4(1,1,1,1)); write_row(1, v4(1,1,1,1)); write_row(2, v4(1,1,1,1));
    do_commit(tc);
    checks++;
    if (err !== 2'b10) begin errors++; $display("FAIL err_incomplete_commit: got %b expected 10", err); end
    checks++;
    if (bank_active !== 1'b0) begin errors++; $display("FAIL err_incomplete_bank: got %b expected 0", bank_active); end
    write_row(5, v4(3,3,3,3));
    checks++;
    if (err !== 2'b11) begin errors++; $display("FAIL err_bad_idx: got %b expected 11", err); end
  endtask

  task automatic test_signed_extremes;
    int tc, e, d;
    load_bank(v4(-128,-128,-128,-128), v4(-128,-128,-128,-128),
              v4(-128,-128,-128,-128), v4(-128,-128,-128,-128), tc);
    checks++;
    if (bank_active !== 1'b1) begin errors++; $display("FAIL ext_bank_active: got %b expected 1", bank_active); end
    obs_q.delete();
    drive_vec(1'b1, v4(-128,-128,-128,-128), e);
    drive_vec(1'b1, v4(127,127,127,127), d);
    ticks(9);
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL ext_count: got %0d expected 2", obs_q.size()); end
    if (obs_q.size() >= 2) begin
      checks++;
      if (obs_q[0].cyc != e + 8 || obs_q[0].d !== r4(65536,65536,65536,65536)) begin
        errors++; $display("FAIL ext_min_min: got edge %0d data %h expected edge %0d data %h", obs_q[0].cyc, obs_q[0].d, e + 8, r4(65536,65536,65536,65536));
      end
      checks++;
      if (obs_q[1].cyc != e + 9 || obs_q[1].d !== r4(-65024,-65024,-65024,-65024)) begin
        errors++; $display("FAIL ext_max_min: got edge %0d data %h expected edge %0d data %h", obs_q[1].cyc, obs_q[1].d, e + 9, r4(-65024,-65024,-65024,-65024));
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ext_busy_idle: got %b expected 0", busy); end
  endtask

  initial begin
    ticks(2);
    reset_n = 1'b1;
    ticks(1);
    test_reset();
    test_identity();
    test_streaming();
    test_back_to_back_swap();
    test_errors();
    test_signed_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
